// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch request/response, data-stage
// request/response, stall outputs and the fixed-latency memory port.
//   slave  : the arbiter's view (requests and mem_rdata in, everything else out)
//   master : the pipeline/memory side view (the mirror image)
interface mem_port_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);
    logic          flush;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_data;
    logic          if_valid;
    logic          stall_fetch;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          stall_mem;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_data, if_valid, stall_fetch, d_rdata, d_valid, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output flush, if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_data, if_valid, stall_fetch, d_rdata, d_valid, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-ported memory between the
// fetch stage and the memory stage. Data requests win over fetch. Each access
// runs IDLE -> WAIT (LATENCY cycles) -> DONE, so one access completes every
// LATENCY+2 cycles. Fetches in flight when flush is seen complete on the
// memory but never raise if_valid.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, data, stall and memory signals)
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 2,
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          squash_q, squash_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] if_data_q, if_data_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          if_valid_q, if_valid_d;
    logic          d_valid_q, d_valid_d;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        squash_d    = squash_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                squash_d = 1'b0;
                if (bus.d_req) begin
                    owner_d     = OWN_DATA;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    cnt_d       = CNT_INIT;
                    state_d     = S_WAIT;
                end else if (bus.if_req && !bus.flush) begin
                    // A fetch flushed at the grant edge is simply never issued.
                    owner_d     = OWN_FETCH;
                    mem_en_d    = 1'b1;
                    mem_addr_d  = bus.if_addr;
                    mem_wdata_d = bus.d_wdata;
                    cnt_d       = CNT_INIT;
                    state_d     = S_WAIT;
                end
            end

            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (owner_q == OWN_FETCH && bus.flush) begin
                    squash_d = 1'b1;
                end
                if (cnt_q == 4'd1) begin
                    state_d = S_DONE;
                    if (owner_q == OWN_FETCH) begin
                        if_data_d  = bus.mem_rdata;
                        // Include this cycle's flush: squash_q only reflects earlier cycles.
                        if_valid_d = !(squash_q || bus.flush);
                    end else begin
                        d_rdata_d = bus.mem_rdata;
                        d_valid_d = 1'b1;
                    end
                end
            end

            S_DONE: begin
                squash_d = 1'b0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_FETCH;
            cnt_q       <= '0;
            squash_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            squash_q    <= squash_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
        end
    end

    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.if_data     = if_data_q;
    assign bus.if_valid    = if_valid_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.d_valid     = d_valid_q;
    assign bus.stall_fetch = bus.if_req & ~if_valid_q;
    assign bus.stall_mem   = bus.d_req & ~d_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter. Main instance uses LATENCY=2 with a memory
// model whose read data is only valid at the correct capture cycle; a second
// LATENCY=1 instance checks back-to-back fetch throughput.
module tb_mem_port_arbiter;
    localparam int unsigned LAT = 2;
    localparam int unsigned AW  = 16;
    localparam int unsigned DW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus2 ();

    mem_port_arbiter #(.LATENCY(LAT), .AW(AW), .DW(DW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.LATENCY(1), .AW(AW), .DW(DW)) u_dut_l1 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    // Memory device: writes on mem_en&mem_we; read data driven only in the
    // cycle that ends at the capture edge (issue edge + LAT), garbage otherwise.
    logic [15:0] mem     [0:4095];
    logic [15:0] ref_mem [0:4095];
    int unsigned age = 15;

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
        if (bus.mem_en) age <= 1;
        else if (age < 15) age <= age + 1;
    end

    always_comb begin
        bus.mem_rdata = 16'hDEAD;
        if (bus.mem_en ? (LAT == 1) : (age == LAT - 1))
            bus.mem_rdata = mem[bus.mem_addr[11:0]];
    end

    always_comb bus2.mem_rdata = bus2.mem_en ? (bus2.mem_addr ^ 16'hC3C3) : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard
    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        int          cyc;
    } iss_t;

    typedef struct {
        logic [15:0] data;
        logic        chk_data;
        int          cyc;
    } rsp_t;

    iss_t exp_iss [$];
    rsp_t exp_f   [$];
    rsp_t exp_d   [$];

    function automatic void push_iss(input logic [15:0] a, input logic we,
                                     input logic [15:0] wd, input int c);
        iss_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.cyc = c;
        exp_iss.push_back(e);
    endfunction

    function automatic void push_f(input logic [15:0] d, input int c);
        rsp_t e;
        e.data = d; e.chk_data = 1'b1; e.cyc = c;
        exp_f.push_back(e);
    endfunction

    function automatic void push_d(input logic [15:0] d, input logic chk_data, input int c);
        rsp_t e;
        e.data = d; e.chk_data = chk_data; e.cyc = c;
        exp_d.push_back(e);
    endfunction

    always @(negedge clk) begin
        iss_t ei;
        rsp_t er;
        if (!rst) begin
            if (bus.mem_en) begin
                if (exp_iss.size() == 0) chk("en_unexpected", bus.mem_en, 0);
                else begin
                    ei = exp_iss.pop_front();
                    chk("iss_cyc", cyc, ei.cyc);
                    chk("iss_addr", bus.mem_addr, ei.addr);
                    chk("iss_we", bus.mem_we, ei.we);
                    if (ei.we) chk("iss_wdata", bus.mem_wdata, ei.wdata);
                end
            end
            if (bus.mem_we) chk("we_with_en", bus.mem_en, 1);
            if (bus.if_valid) begin
                if (exp_f.size() == 0) chk("if_unexpected", bus.if_valid, 0);
                else begin
                    er = exp_f.pop_front();
                    chk("if_cyc", cyc, er.cyc);
                    if (er.chk_data) chk("if_data", bus.if_data, er.data);
                end
            end
            if (bus.d_valid) begin
                if (exp_d.size() == 0) chk("d_unexpected", bus.d_valid, 0);
                else begin
                    er = exp_d.pop_front();
                    chk("d_cyc", cyc, er.cyc);
                    if (er.chk_data) chk("d_rdata", bus.d_rdata, er.data);
                end
            end
        end
    end

    // Requester tasks: start at a negedge, hold the request until valid.
    task automatic do_fetch(input logic [15:0] a);
        bit got = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.if_valid) begin
                got = 1'b1;
                chk("stall_fetch_done", bus.stall_fetch, 0);
            end else begin
                chk("stall_fetch", bus.stall_fetch, 1);
            end
        end
        if (!got) chk("if_timeout", got, 1);
        bus.if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
        bit got = 1'b0;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = a;
        bus.d_wdata = wd;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (bus.d_valid) begin
                got = 1'b1;
                chk("stall_mem_done", bus.stall_mem, 0);
            end else begin
                chk("stall_mem", bus.stall_mem, 1);
            end
        end
        if (!got) chk("d_timeout", got, 1);
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
    endtask

    initial begin
        int c;
        int last_en;
        int n_en;
        int n_v;
        logic [15:0] a2;

        bus.flush = 0; bus.if_req = 0; bus.if_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus2.flush = 0; bus2.if_req = 0; bus2.if_addr = '0;
        bus2.d_req = 0; bus2.d_we = 0; bus2.d_addr = '0; bus2.d_wdata = '0;

        for (int i = 0; i < 4096; i++) begin
            ref_mem[i] = 16'((i * 37) ^ 16'h5A5A);
            mem[i]    <= 16'((i * 37) ^ 16'h5A5A);
        end
        ref_mem[16'h0010] = 16'h1234;
        mem[16'h0010]    <= 16'h1234;

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_d_valid", bus.d_valid, 0);
        chk("rst_if_data", bus.if_data, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Single fetch read
        c = cyc;
        push_iss(16'h0010, 0, 0, c + 1);
        push_f(ref_mem[16'h0010], c + 1 + LAT);
        do_fetch(16'h0010);
        @(negedge clk);

        // Simultaneous: data first, fetch in the IDLE after data's DONE
        c = cyc;
        push_iss(16'h0200, 0, 0, c + 1);
        push_d(ref_mem[16'h0200], 1, c + 1 + LAT);
        push_iss(16'h0011, 0, 0, c + 3 + LAT);
        push_f(ref_mem[16'h0011], c + 3 + 2 * LAT);
        fork
            do_data(1'b0, 16'h0200, 16'h0000);
            do_fetch(16'h0011);
        join
        @(negedge clk);

        // Store then read back
        c = cyc;
        push_iss(16'h0300, 1, 16'hBEEF, c + 1);
        push_d(16'h0000, 0, c + 1 + LAT);
        ref_mem[16'h0300] = 16'hBEEF;
        do_data(1'b1, 16'h0300, 16'hBEEF);
        @(negedge clk);
        c = cyc;
        push_iss(16'h0300, 0, 0, c + 1);
        push_d(ref_mem[16'h0300], 1, c + 1 + LAT);
        do_data(1'b0, 16'h0300, 16'h0000);
        @(negedge clk);

        // Flush during WAIT of a fetch: memory access happens, no if_valid
        c = cyc;
        push_iss(16'h0020, 0, 0, c + 1);
        bus.if_req = 1'b1; bus.if_addr = 16'h0020;
        repeat (2) @(negedge clk);
        bus.flush = 1'b1; bus.if_req = 1'b0;
        @(negedge clk);
        bus.flush = 1'b0;
        while (cyc < c + 2 + LAT) @(negedge clk);
        c = cyc;
        push_iss(16'h0040, 0, 0, c + 1);
        push_f(ref_mem[16'h0040], c + 1 + LAT);
        do_fetch(16'h0040);
        @(negedge clk);

        // Flush at the grant edge: fetch never issued
        bus.if_req = 1'b1; bus.if_addr = 16'h0060; bus.flush = 1'b1;
        @(negedge clk);
        bus.if_req = 1'b0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        c = cyc;
        push_iss(16'h0060, 0, 0, c + 1);
        push_f(ref_mem[16'h0060], c + 1 + LAT);
        do_fetch(16'h0060);
        @(negedge clk);

        // Reset mid-access: outputs clear asynchronously, no valid afterwards
        c = cyc;
        push_iss(16'h0050, 0, 0, c + 1);
        bus.if_req = 1'b1; bus.if_addr = 16'h0050;
        @(negedge clk);
        #2;
        rst = 1'b1; bus.if_req = 1'b0;
        #1;
        chk("arst_mem_en", bus.mem_en, 0);
        chk("arst_mem_addr", bus.mem_addr, 0);
        chk("arst_if_data", bus.if_data, 0);
        chk("arst_d_rdata", bus.d_rdata, 0);
        chk("arst_if_valid", bus.if_valid, 0);
        chk("arst_stall_fetch", bus.stall_fetch, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        c = cyc;
        push_iss(16'h0010, 0, 0, c + 1);
        push_f(ref_mem[16'h0010], c + 1 + LAT);
        do_fetch(16'h0010);
        @(negedge clk);

        // Back-to-back fetches on the LATENCY=1 instance
        last_en = -1; n_en = 0; n_v = 0; a2 = 16'h0100;
        bus2.if_req = 1'b1; bus2.if_addr = a2;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus2.mem_en) begin
                if (last_en >= 0) chk("b2b_period", cyc - last_en, 3);
                chk("b2b_addr", bus2.mem_addr, a2);
                last_en = cyc;
                n_en++;
            end
            if (bus2.if_valid) begin
                chk("b2b_lag", cyc - last_en, 1);
                chk("b2b_data", bus2.if_data, a2 ^ 16'hC3C3);
                a2 = a2 + 16'd1;
                bus2.if_addr = a2;
                n_v++;
            end
        end
        bus2.if_req = 1'b0;
        chk("b2b_en_count", n_en, 7);
        chk("b2b_valid_count", n_v, 7);

        repeat (4) @(negedge clk);
        chk("iss_q_empty", exp_iss.size(), 0);
        chk("f_q_empty", exp_f.size(), 0);
        chk("d_q_empty", exp_d.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
